// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: prescaled tick, 8-bit saturating level.
// Optional ADSR_EXP_RELEASE_EN selects an exponential-like release tail.
module adsr_envelope_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate,
    input  logic [7:0] attack_step,
    input  logic [7:0] decay_step,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_step,
    output logic [7:0] env_level,
    output logic [2:0] env_state,
    output logic       env_busy,
    output logic       env_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  nxt_level;
    logic        nxt_done;
    logic [15:0] pre_cnt;
    logic        tick;
    logic        gate_s;
    logic        gate_d;
    logic        rise;
    logic [8:0]  att_sum;
    logic [8:0]  dec_floor;
    logic [8:0]  rel_dec;
    logic        rel_inst;

    assign tick      = (pre_cnt == TICK_LAST);
    assign rise      = gate_s & ~gate_d;
    assign env_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // gate is sampled once before edge detection, giving 2-clk response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_s <= 1'b0;
            gate_d <= 1'b0;
        end else begin
            gate_s <= gate;
            gate_d <= gate_s;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_level = env_level;
        nxt_done  = 1'b0;
        att_sum   = {1'b0, env_level} + {1'b0, attack_step};
        dec_floor = {1'b0, sustain_level} + {1'b0, decay_step};
`ifdef ADSR_EXP_RELEASE_EN
        rel_dec   = {4'b0, env_level[7:3]} + {1'b0, release_step};
        if (rel_dec == 9'd0) begin
            rel_dec = 9'd1;
        end
        rel_inst  = 1'b0;
`else
        rel_dec   = {1'b0, release_step};
        rel_inst  = (release_step == 8'd0);
`endif
        if (rise) begin
            nxt_state = ATTACK;
        end else if (!gate_s && (state == ATTACK || state == DECAY
                                 || state == SUSTAIN)) begin
            nxt_state = RELEASE;
        end else begin
            case (state)
                IDLE: begin
                    nxt_level = 8'd0;
                end
                ATTACK: begin
                    if (tick) begin
                        if (attack_step == 8'd0 || att_sum >= 9'd255) begin
                            nxt_level = 8'd255;
                            nxt_state = DECAY;
                        end else begin
                            nxt_level = att_sum[7:0];
                        end
                    end
                end
                DECAY: begin
                    // level - step <= sustain, rewritten to avoid underflow
                    if (tick) begin
                        if (decay_step == 8'd0
                            || {1'b0, env_level} <= dec_floor) begin
                            nxt_level = sustain_level;
                            nxt_state = SUSTAIN;
                        end else begin
                            nxt_level = env_level - decay_step;
                        end
                    end
                end
                SUSTAIN: begin
                    nxt_level = sustain_level;
                end
                RELEASE: begin
                    if (tick) begin
                        if (rel_inst || {1'b0, env_level} <= rel_dec) begin
                            nxt_level = 8'd0;
                            nxt_state = IDLE;
                            nxt_done  = 1'b1;
                        end else begin
                            nxt_level = env_level - rel_dec[7:0];
                        end
                    end
                end
                default: begin
                    nxt_level = 8'd0;
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            env_level <= 8'd0;
            env_busy  <= 1'b0;
            env_done  <= 1'b0;
        end else begin
            state     <= nxt_state;
            env_level <= nxt_level;
            env_busy  <= (nxt_state != IDLE);
            env_done  <= nxt_done;
        end
    end

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Self-checking bench for adsr_envelope_gen (TICK_DIV=4).
// Directed test-plan scenarios plus randomized run against a reference model.
module tb_adsr_envelope_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       gate;
    logic [7:0] attack_step;
    logic [7:0] decay_step;
    logic [7:0] sustain_level;
    logic [7:0] release_step;
    logic [7:0] env_level;
    logic [2:0] env_state;
    logic       env_busy;
    logic       env_done;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    int m_st, m_lvl, m_done, gh1, gh2;

    adsr_envelope_gen #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .reset(reset),
        .gate(gate),
        .attack_step(attack_step),
        .decay_step(decay_step),
        .sustain_level(sustain_level),
        .release_step(release_step),
        .env_level(env_level),
        .env_state(env_state),
        .env_busy(env_busy),
        .env_done(env_done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gate  = 1'b0;
        cyc();
        cyc();
        reset  = 1'b0;
        ecount = 0;
        m_st = 0; m_lvl = 0; m_done = 0; gh1 = 0; gh2 = 0;
    endtask

    task automatic set_steps(input int a, input int d, input int s, input int r);
        attack_step   = 8'(a);
        decay_step    = 8'(d);
        sustain_level = 8'(s);
        release_step  = 8'(r);
    endtask

    // Wait (bounded) for env_level to change; ok=0 on timeout.
    task automatic next_level(output bit ok);
        logic [7:0] p;
        p  = env_level;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (env_level !== p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: edge k (0-based since reset) is a tick when k mod TD == TD-1;
    // the FSM sees the gate as it was one and two edges earlier.
    task automatic model_update();
        bit tick, rise;
        int dec;
        bit inst;
        tick = (((ecount - 1) % TD) == TD - 1);
        rise = (gh1 == 1) && (gh2 == 0);
        m_done = 0;
        if (rise) begin
            m_st = 1;
        end else if (gh1 == 0 && m_st >= 1 && m_st <= 3) begin
            m_st = 4;
        end else if (m_st == 0) begin
            m_lvl = 0;
        end else if (m_st == 3) begin
            m_lvl = int'(sustain_level);
        end else if (tick && m_st == 1) begin
            if (attack_step == 0 || m_lvl + int'(attack_step) >= 255) begin
                m_lvl = 255; m_st = 2;
            end else begin
                m_lvl += int'(attack_step);
            end
        end else if (tick && m_st == 2) begin
            if (decay_step == 0 || m_lvl - int'(decay_step) <= int'(sustain_level)) begin
                m_lvl = int'(sustain_level); m_st = 3;
            end else begin
                m_lvl -= int'(decay_step);
            end
        end else if (tick && m_st == 4) begin
`ifdef ADSR_EXP_RELEASE_EN
            dec = (m_lvl / 8) + int'(release_step);
            if (dec < 1) dec = 1;
            inst = 1'b0;
`else
            dec  = int'(release_step);
            inst = (release_step == 0);
`endif
            if (inst || m_lvl <= dec) begin
                m_lvl = 0; m_st = 0; m_done = 1;
            end else begin
                m_lvl -= dec;
            end
        end
        gh2 = gh1;
        gh1 = int'(gate);
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        set_steps(64, 16, 128, 32);
        gate = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (env_level == 8'd128) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || env_state !== 3'd1) begin
            errors++;
            $display("FAIL reset_setup: level=%0d state=%0d, need 128 in state 1",
                     env_level, env_state);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (env_level !== 8'd0 || env_state !== 3'd0 || env_busy !== 1'b0
            || env_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: level=%0d state=%0d busy=%b done=%b, need 0/0/0/0",
                     env_level, env_state, env_busy, env_done);
        end
        gate = 1'b0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (env_level !== 8'd0 || env_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold: cycle %0d level=%0d state=%0d, need 0/0",
                         i, env_level, env_state);
            end
        end
    endtask

    task automatic test_full_cycle();
        bit ok;
        logic [7:0] seq [12];
        seq = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd239, 8'd223,
                8'd207, 8'd191, 8'd175, 8'd159, 8'd143, 8'd128};
        do_reset();
        set_steps(64, 16, 128, 32);
        gate = 1'b1;
        cyc();
        cyc();
        checks++;
        if (env_state !== 3'd1 || env_busy !== 1'b1) begin
            errors++;
            $display("FAIL attack_entry: state=%0d busy=%b, need 1/1",
                     env_state, env_busy);
        end
        for (int i = 0; i < 12; i++) begin
            next_level(ok);
            checks++;
            if (!ok || env_level !== seq[i]) begin
                errors++;
                $display("FAIL full_cycle[%0d]: level=%0d, need %0d", i, env_level, seq[i]);
            end
            if (i == 3) begin
                checks++;
                if (env_state !== 3'd2) begin
                    errors++;
                    $display("FAIL attack_to_decay: state=%0d, need 2", env_state);
                end
            end
        end
        checks++;
        if (env_state !== 3'd3) begin
            errors++;
            $display("FAIL sustain_entry: state=%0d, need 3", env_state);
        end
    endtask

    task automatic test_release();
        bit ok;
        logic [7:0] seq [4];
        seq = '{8'd96, 8'd64, 8'd32, 8'd0};
        gate = 1'b0;
        cyc();
        checks++;
        if (env_state !== 3'd3) begin
            errors++;
            $display("FAIL release_latency: state=%0d after 1 clk, need 3", env_state);
        end
        cyc();
        checks++;
        if (env_state !== 3'd4 || env_level !== 8'd128) begin
            errors++;
            $display("FAIL release_entry: state=%0d level=%0d, need 4/128",
                     env_state, env_level);
        end
        for (int i = 0; i < 4; i++) begin
            next_level(ok);
            checks++;
            if (!ok || env_level !== seq[i]) begin
                errors++;
                $display("FAIL release[%0d]: level=%0d, need %0d", i, env_level, seq[i]);
            end
        end
        checks++;
        if (env_state !== 3'd0 || env_done !== 1'b1 || env_busy !== 1'b0) begin
            errors++;
            $display("FAIL release_end: state=%0d done=%b busy=%b, need 0/1/0",
                     env_state, env_done, env_busy);
        end
        cyc();
        checks++;
        if (env_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, need 0", env_done);
        end
    endtask

    task automatic test_retrigger();
        bit ok;
        do_reset();
        set_steps(64, 16, 128, 32);
        gate = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (env_state == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        gate = 1'b0;
        for (int i = 0; i < 40 && env_level != 8'd64; i++) cyc();
        checks++;
        if (!ok || env_level !== 8'd64 || env_state !== 3'd4) begin
            errors++;
            $display("FAIL retrig_setup: level=%0d state=%0d, need 64/4",
                     env_level, env_state);
        end
        gate = 1'b1;
        cyc();
        cyc();
        checks++;
        if (env_state !== 3'd1 || env_level !== 8'd64) begin
            errors++;
            $display("FAIL retrig_entry: state=%0d level=%0d, need 1/64",
                     env_state, env_level);
        end
        next_level(ok);
        checks++;
        if (!ok || env_level !== 8'd128) begin
            errors++;
            $display("FAIL retrig_continue: level=%0d, need 128", env_level);
        end
    endtask

    task automatic test_zero_steps();
        bit ok;
        logic [7:0] held;
        do_reset();
        set_steps(0, 0, 100, 0);
        gate = 1'b1;
        next_level(ok);
        checks++;
        if (!ok || env_level !== 8'd255 || env_state !== 3'd2) begin
            errors++;
            $display("FAIL zero_attack: level=%0d state=%0d, need 255/2",
                     env_level, env_state);
        end
        next_level(ok);
        checks++;
        if (!ok || env_level !== 8'd100 || env_state !== 3'd3) begin
            errors++;
            $display("FAIL zero_decay: level=%0d state=%0d, need 100/3",
                     env_level, env_state);
        end
        gate = 1'b0;
        next_level(ok);
        checks++;
        if (!ok || env_level !== 8'd0 || env_state !== 3'd0 || env_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_release: level=%0d state=%0d done=%b, need 0/0/1",
                     env_level, env_state, env_done);
        end
        // rise lands on a tick edge while releasing
        set_steps(0, 0, 200, 16);
        gate = 1'b1;
        for (int i = 0; i < 40 && env_state != 3'd3; i++) cyc();
        gate = 1'b0;
        for (int i = 0; i < 40 && env_level != 8'd184; i++) cyc();
        for (int i = 0; i < 8 && ((ecount - 1) % TD) != 1; i++) cyc();
        held = env_level;
        checks++;
        if (held !== 8'd184 || env_state !== 3'd4) begin
            errors++;
            $display("FAIL tick_rise_setup: level=%0d state=%0d, need 184/4",
                     held, env_state);
        end
        gate = 1'b1;
        cyc();
        cyc();
        checks++;
        if (env_state !== 3'd1 || env_level !== 8'd184) begin
            errors++;
            $display("FAIL tick_rise: state=%0d level=%0d, need 1/184",
                     env_state, env_level);
        end
        next_level(ok);
        checks++;
        if (!ok || env_level !== 8'd255) begin
            errors++;
            $display("FAIL tick_rise_attack: level=%0d, need 255", env_level);
        end
    endtask

`ifdef ADSR_EXP_RELEASE_EN
    task automatic test_exp_release();
        bit ok;
        int pulses;
        logic [7:0] seq [4];
        seq = '{8'd112, 8'd98, 8'd86, 8'd76};
        do_reset();
        set_steps(0, 0, 128, 0);
        gate = 1'b1;
        for (int i = 0; i < 40 && env_state != 3'd3; i++) cyc();
        gate = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            next_level(ok);
            checks++;
            if (!ok || env_level !== seq[i]) begin
                errors++;
                $display("FAIL exp_release[%0d]: level=%0d, need %0d",
                         i, env_level, seq[i]);
            end
        end
        pulses = 0;
        for (int i = 0; i < 400 && env_state != 3'd0; i++) begin
            cyc();
            if (env_done === 1'b1) pulses++;
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (env_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || env_level !== 8'd0 || env_state !== 3'd0) begin
            errors++;
            $display("FAIL exp_release_end: pulses=%0d level=%0d state=%0d, need 1/0/0",
                     pulses, env_level, env_state);
        end
    endtask
`endif

    task automatic test_random();
        int lim;
        do_reset();
        set_steps($urandom_range(1, 80), $urandom_range(1, 40),
                  $urandom_range(0, 255), $urandom_range(1, 60));
        lim = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: attack_step   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                    1: decay_step    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                    2: sustain_level = 8'($urandom);
                    default: release_step = ($urandom_range(0, 5) == 0) ? 8'd0
                                                                       : 8'($urandom_range(1, 40));
                endcase
            end
            cyc();
            model_update();
            checks++;
            if (env_level !== 8'(m_lvl) || env_state !== 3'(m_st)
                || env_busy !== (m_st != 0) || env_done !== 1'(m_done)) begin
                errors++;
                if (lim < 20) begin
                    lim++;
                    $display("FAIL random[%0d]: level=%0d state=%0d busy=%b done=%b, need %0d/%0d/%0d/%0d",
                             n, env_level, env_state, env_busy, env_done,
                             m_lvl, m_st, (m_st != 0), m_done);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        gate  = 1'b0;
        set_steps(0, 0, 0, 0);
        #3;
        checks++;
        if (env_level !== 8'd0 || env_state !== 3'd0 || env_busy !== 1'b0
            || env_done !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset: level=%0d state=%0d busy=%b done=%b, need 0",
                     env_level, env_state, env_busy, env_done);
        end
        test_reset();
        test_full_cycle();
        test_release();
        test_retrigger();
        test_zero_steps();
`ifdef ADSR_EXP_RELEASE_EN
        test_exp_release();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
- Standalone ADSR envelope generator that produces the 8-bit amplitude envelope used to scale the sawtooth oscillator output in the modulation stage.
- Sits directly upstream of the multiplier/modulation stage; gate comes from the note control logic.
- Integer step-per-tick model; a prescaler sets the envelope time base.
- Fully registered outputs; saturating arithmetic throughout.

Parameters:
TICK_DIV, 25000, clk cycles per envelope tick (1 kHz at 25 MHz); legal range 2..65535

Ports:
clk  input  1  system clock (25 MHz)
reset  input  1  asynchronous, active-high reset
gate  input  1  note held (1) / released (0); synchronous to clk
attack_step  input  8  level increment per tick in ATTACK
decay_step  input  8  level decrement per tick in DECAY
sustain_level  input  8  hold level in SUSTAIN and floor of DECAY
release_step  input  8  level decrement per tick in RELEASE
env_level  output  8  current envelope amplitude, 0..255
env_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
env_busy  output  1  high when env_state != IDLE
env_done  output  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset values: env_level=0, env_state=IDLE, env_busy=0, env_done=0, prescaler=0, gate_d=0.
- Prescaler:
  - Free-running 16-bit counter, 0..TICK_DIV-1.
  - tick=1 on the cycle the counter equals TICK_DIV-1, after which it wraps to 0.
  - Gate activity does not reset the prescaler.
- Gate edge detection:
  - gate_d is gate registered one cycle.
  - rise = gate & ~gate_d; fall = ~gate & gate_d.
- Gate-driven transitions act on the next clk edge and do not wait for a tick:
  - rise in any state -> ATTACK. Retrigger: level continues from its current value and does not jump.
  - gate low while in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - fall in IDLE or RELEASE -> ignored.
  - rise and tick in the same cycle: the rise wins. State becomes ATTACK and level is unchanged that cycle.
- Tick-driven updates (only when tick=1 and no rise). All sums use 9-bit arithmetic and saturate.
  - ATTACK:
    - level+attack_step >= 255 -> level=255, state DECAY.
    - Otherwise level += attack_step.
    - attack_step=0 means instant: 255 on the first tick.
  - DECAY:
    - level-decay_step <= sustain_level, or level <= sustain_level -> level=sustain_level, state SUSTAIN.
    - Otherwise level -= decay_step.
    - decay_step=0 means instant: jump to sustain on the first tick.
  - SUSTAIN: level follows sustain_level every cycle, not only on ticks.
  - RELEASE:
    - level <= release_step -> level=0, state IDLE, env_done=1 for that one cycle.
    - Otherwise level -= release_step.
    - release_step=0 means instant: 0 on the first tick.
  - IDLE: level held at 0.
- Latency:
  - env_state changes 1 cycle after the gate edge is registered, i.e. 2 clk after a gate change.
  - env_level updates in the cycle after tick.
- Reset asserted mid-envelope returns all state to reset values immediately (asynchronous).
- Step and level inputs are sampled on every tick; changing them mid-phase takes effect on the next tick.
- Undefined state encodings (5..7) -> IDLE, level=0.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: RELEASE decrement = (level >> 3) + release_step, forced to at least 1, giving an exponential-like tail. The termination rule is unchanged: when level <= decrement, level=0 and state IDLE.
- Not defined: linear release exactly as in Behaviour.
- No other behaviour differs.

Test Plan:
(All scenarios use TICK_DIV=4.)
1. Reset: assert reset mid-ATTACK with level 128 -> env_level=0, env_state=0, env_busy=0 immediately; level stays 0 after release with gate=0.
2. Full cycle: attack_step=64, decay_step=16, sustain=128, gate=1.
   - ATTACK ticks give 64, 128, 192, 255.
   - DECAY ticks give 239, 223, 207, 191, 175, 159, 143, then 128 (clamped) with env_state=3.
3. Release: from SUSTAIN 128, release_step=32, gate=0 -> RELEASE; ticks give 96, 64, 32, 0, then env_state=0 with env_done high for exactly 1 cycle.
4. Retrigger: gate re-raised during RELEASE at level 64 with attack_step=64 -> ATTACK 2 clk later; next tick gives 128, with no drop to 0.
5. Zero steps:
   - attack_step=0 -> 255 on first tick.
   - decay_step=0 -> sustain on next tick.
   - release_step=0 -> 0 plus env_done on first release tick.
   - Rise coincident with tick -> ATTACK with level unchanged that cycle.
6. With ADSR_EXP_RELEASE_EN defined: level 128, release_step=0 -> ticks give 112, 98, 86, 76, …, reaching 0 via the min-1 decrement; env_done pulses once.
